// File: rtl/alu_vectorial_pkg.sv
// Shared types and default sizing for the vector ALU pipeline.
package alu_vectorial_pkg;

    localparam int unsigned DefaultLanes = 16;
    localparam int unsigned DefaultLw    = 8;

    typedef enum logic [2:0] {
        OP_ZERO   = 3'b000,
        OP_PASS_A = 3'b001,
        OP_ADD    = 3'b010,
        OP_SUB    = 3'b011,
        OP_MUL    = 3'b100,
        OP_DIV    = 3'b101,
        OP_ZERO2  = 3'b110,
        OP_PASS_B = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_e;

endpackage

// File: rtl/VectorialDivisionSeq.sv
// Lane-parallel restoring divider: one quotient bit per lane per step, MSB first.
module VectorialDivisionSeq
    import alu_vectorial_pkg::*;
#(
    parameter int unsigned LANES = DefaultLanes,
    parameter int unsigned LW    = DefaultLw
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                step,
    input  logic [LANES*LW-1:0] a,
    input  logic [LANES*LW-1:0] b,
    output logic [LANES*LW-1:0] q
);

    logic [LANES*LW-1:0] rem_q, quot_q, dvs_q;
    logic [LANES*LW-1:0] rem_step, quot_step;
    logic [LANES-1:0]    dz_q, dz_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LW:0] trial;
        logic [LW:0] diff;
        logic        fits;

        // Shift the next dividend bit (taken from the quotient register MSB) into the remainder.
        assign trial = {rem_q[i*LW +: LW], quot_q[i*LW+LW-1]};
        assign diff  = trial - {1'b0, dvs_q[i*LW +: LW]};
        assign fits  = !diff[LW];

        assign rem_step[i*LW +: LW]  = fits ? diff[LW-1:0] : trial[LW-1:0];
        assign quot_step[i*LW +: LW] = {quot_q[i*LW +: LW-1], fits};
        assign dz_d[i]               = (b[i*LW +: LW] == '0);
        assign q[i*LW +: LW]         = dz_q[i] ? {LW{1'b1}} : quot_q[i*LW +: LW];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            dz_q   <= '0;
        end else if (start) begin
            rem_q  <= '0;
            quot_q <= a;
            dvs_q  <= b;
            dz_q   <= dz_d;
        end else if (step) begin
            rem_q  <= rem_step;
            quot_q <= quot_step;
        end
    end

endmodule

// File: rtl/alu_vectorial_pipe.sv
// Registered, handshaked vector ALU with iterative divide.
// Define ALUV_SAT_EN for per-lane saturating add/sub/mul.
module alu_vectorial_pipe
    import alu_vectorial_pkg::*;
#(
    parameter int unsigned LANES = DefaultLanes,
    parameter int unsigned LW    = DefaultLw
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES*LW-1:0] A,
    input  logic [LANES*LW-1:0] B,
    input  logic [2:0]          Sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LANES*LW-1:0] C,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int unsigned N    = LANES * LW;
    localparam int unsigned CntW = (LW > 1) ? $clog2(LW) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(LW - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    c_q, c_d;
    logic            ov_q, ov_d;
    logic            busy_q, busy_d;

    logic [N-1:0] sc_res;
    logic [N-1:0] div_q;
    logic         accept;
    logic         div_start, div_step;
    op_e          op;

    assign op = op_e'(Sel);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LW-1:0] a_l, b_l, add_l, sub_l, mul_l, res_l;

        assign a_l = A[i*LW +: LW];
        assign b_l = B[i*LW +: LW];

`ifdef ALUV_SAT_EN
        logic [LW:0]     sum_w, dif_w;
        logic [2*LW-1:0] prod_w;

        assign sum_w  = {1'b0, a_l} + {1'b0, b_l};
        assign dif_w  = {1'b0, a_l} - {1'b0, b_l};
        assign prod_w = {{LW{1'b0}}, a_l} * {{LW{1'b0}}, b_l};
        assign add_l  = sum_w[LW] ? {LW{1'b1}} : sum_w[LW-1:0];
        assign sub_l  = dif_w[LW] ? '0 : dif_w[LW-1:0];
        assign mul_l  = (|prod_w[2*LW-1:LW]) ? {LW{1'b1}} : prod_w[LW-1:0];
`else
        assign add_l = a_l + b_l;
        assign sub_l = a_l - b_l;
        assign mul_l = a_l * b_l;
`endif

        always_comb begin
            res_l = '0;
            unique case (op)
                OP_PASS_A: res_l = a_l;
                OP_PASS_B: res_l = b_l;
                OP_ADD:    res_l = add_l;
                OP_SUB:    res_l = sub_l;
                OP_MUL:    res_l = mul_l;
                OP_ZERO, OP_ZERO2, OP_DIV: res_l = '0;
            endcase
        end

        assign sc_res[i*LW +: LW] = res_l;
    end

    VectorialDivisionSeq #(
        .LANES(LANES),
        .LW   (LW)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .start(div_start),
        .step (div_step),
        .a    (A),
        .b    (B),
        .q    (div_q)
    );

    // Held low during reset so nothing is accepted into a block being cleared.
    assign in_ready = rst && (state_q == IDLE) && (!ov_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        c_d       = c_q;
        ov_d      = ov_q && !out_ready;
        div_start = 1'b0;
        div_step  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_DIV) begin
                        div_start = 1'b1;
                        cnt_d     = '0;
                        state_d   = DIV;
                    end else begin
                        c_d  = sc_res;
                        ov_d = 1'b1;
                    end
                end
            end
            DIV: begin
                div_step = 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!ov_q || out_ready) begin
                    c_d     = div_q;
                    ov_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_q     <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
        end
    end

    assign C         = c_q;
    assign out_valid = ov_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_vectorial_pipe.sv
// Directed self-checking bench for alu_vectorial_pipe (LANES=16, LW=8).
module tb_alu_vectorial_pipe;

    localparam int LANES = 16;
    localparam int LW    = 8;
    localparam int N     = LANES * LW;

`ifdef ALUV_SAT_EN
    localparam logic [7:0] ExpAdd = 8'hFF;
    localparam logic [7:0] ExpSub = 8'h00;
    localparam logic [7:0] ExpMul = 8'hFF;
`else
    localparam logic [7:0] ExpAdd = 8'h2C;
    localparam logic [7:0] ExpSub = 8'hF6;
    localparam logic [7:0] ExpMul = 8'h40;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] A, B, C;
    logic [2:0]   Sel;
    logic         in_valid, in_ready, out_valid, out_ready, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_vectorial_pipe #(
        .LANES(LANES),
        .LW   (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Sel      (Sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .C        (C),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    function automatic logic [N-1:0] fill(input logic [7:0] v);
        fill = {LANES{v}};
    endfunction

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Sel = 3'b000;
        repeat (3) @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (C !== '0) begin n_err++; $display("FAIL reset_c: got %h want 0", C); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    // One single-cycle op: accept on the next edge, result must be visible right after it.
    task automatic test_arith(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] sel, input logic [7:0] exp);
        A = fill(a); B = fill(b); Sel = sel; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_out_valid: got %b want 1", name, out_valid); end
        n_vec++; if (C !== fill(exp)) begin n_err++; $display("FAIL %s_c: got %h want %h", name, C, fill(exp)); end
    endtask

    task automatic test_pass_zero;
        logic [2:0]   sels [4];
        logic [N-1:0] exps [4];
        sels = '{3'b001, 3'b111, 3'b000, 3'b110};
        exps = '{fill(8'h11), fill(8'h22), '0, '0};
        A = fill(8'h11); B = fill(8'h22); out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Sel = sels[i];
            #1;
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pass_in_ready[%0d]: got %b want 1", i, in_ready); end
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pass_out_valid[%0d]: got %b want 1", i, out_valid); end
            n_vec++; if (C !== exps[i]) begin n_err++; $display("FAIL pass_c[%0d]: got %h want %h", i, C, exps[i]); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_div;
        logic [N-1:0] bv, exp;
        bv = fill(8'h07); bv[7:0] = 8'h00;
        exp = fill(8'h1C); exp[7:0] = 8'hFF;
        A = fill(8'd200); B = bv; Sel = 3'b101; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; A = '0; B = '0;
        for (int i = 0; i < LW + 1; i++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL div_in_ready[%0d]: got %b want 0", i, in_ready); end
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL div_busy[%0d]: got %b want 1", i, busy); end
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL div_early_valid[%0d]: got %b want 0", i, out_valid); end
            @(negedge clk);
        end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL div_out_valid: got %b want 1", out_valid); end
        n_vec++; if (C !== exp) begin n_err++; $display("FAIL div_c: got %h want %h", C, exp); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL div_busy_end: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL div_in_ready_end: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        Sel = 3'b010; out_ready = 1'b1;
        A = fill(8'd1); B = fill(8'd2); in_valid = 1'b1;
        @(negedge clk);
        n_vec++; if (C !== fill(8'd3) || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %h/%b want %h/1", C, out_valid, fill(8'd3)); end
        out_ready = 1'b0; A = fill(8'd10); B = fill(8'd20);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready[%0d]: got %b want 0", i, in_ready); end
            n_vec++; if (C !== fill(8'd3) || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_hold[%0d]: got %h/%b want %h/1", i, C, out_valid, fill(8'd3)); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        n_vec++; if (C !== fill(8'd30) || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second: got %h/%b want %h/1", C, out_valid, fill(8'd30)); end
        A = fill(8'd100); B = fill(8'd27);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (C !== fill(8'd127) || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_third: got %h/%b want %h/1", C, out_valid, fill(8'd127)); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_div_reset;
        A = fill(8'd200); B = fill(8'd7); Sel = 3'b101; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL divrst_busy_before: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL divrst_in_ready_low: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL divrst_busy: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL divrst_idle: got %b want 1", in_ready); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL divrst_no_result[%0d]: got %b want 0", i, out_valid); end
        end
        test_arith("divrst_add", 8'd3, 8'd4, 3'b010, 8'd7);
    endtask

    initial begin
        test_reset();
        test_arith("add", 8'd200, 8'd100, 3'b010, ExpAdd);
        test_arith("sub", 8'd10, 8'd20, 3'b011, ExpSub);
        test_arith("mul", 8'd16, 8'd20, 3'b100, ExpMul);
        test_pass_zero();
        test_div();
        test_back_to_back();
        test_div_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
